// File: rtl/washer_dispenser.sv
// Washer dispenser: synchronises request edges, queues up to 3, and cycles the servo DOWN/UP per washer.
// Define WASHER_DISPENSER_COUNT_EN to build the completed-dispense counter on dispCount.
module washer_dispenser #(
   parameter int DIV        = 100000,
   parameter int DOWN_TICKS = 300,
   parameter int UP_TICKS   = 300
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       request,
   output logic       controlServo,
   output logic       busy,
   output logic       done,
   output logic       overflow,
   output logic [7:0] dispCount
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int MT = (DOWN_TICKS > UP_TICKS) ? DOWN_TICKS : UP_TICKS;
   localparam int TW = (MT > 1) ? $clog2(MT) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
   localparam logic [TW-1:0] DOWN_LAST = TW'(DOWN_TICKS - 1);
   localparam logic [TW-1:0] UP_LAST   = TW'(UP_TICKS - 1);

   typedef enum logic [1:0] {IDLE, DOWN, UP, DONE} state_t;

   state_t        state, state_nxt;
   logic          sync1, sync2, hist;
   logic [2:0]    vld_pipe;
   logic          req_edge, leave_idle, tick_wrap;
   logic [1:0]    pending;
   logic [PW-1:0] presc;
   logic [TW-1:0] ticks;

   // vld_pipe holds off edge detection until sync2 and hist both carry post-reset
   // samples, so a request held high through reset release is not an edge.
   assign req_edge   = sync2 & ~hist & vld_pipe[2];
   assign leave_idle = (state == IDLE) && (pending != 2'd0);
   assign tick_wrap  = (presc == PRE_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pending != 2'd0) state_nxt = DOWN;
         DOWN:    if (tick_wrap && ticks == DOWN_LAST) state_nxt = UP;
         UP:      if (tick_wrap && ticks == UP_LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         sync1        <= 1'b0;
         sync2        <= 1'b0;
         hist         <= 1'b0;
         vld_pipe     <= 3'b000;
         pending      <= 2'd0;
         overflow     <= 1'b0;
         presc        <= '0;
         ticks        <= '0;
         controlServo <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state    <= state_nxt;
         sync1    <= request;
         sync2    <= sync1;
         hist     <= sync2;
         vld_pipe <= {vld_pipe[1:0], 1'b1};

         if (req_edge && !leave_idle) begin
            if (pending == 2'd3) overflow <= 1'b1;
            else                 pending  <= pending + 2'd1;
         end else if (!req_edge && leave_idle) begin
            pending <= pending - 2'd1;
         end

         // Timers restart on every state entry so phase lengths never depend on request timing.
         if (state_nxt != state) begin
            presc <= '0;
            ticks <= '0;
         end else if (state == DOWN || state == UP) begin
            if (tick_wrap) begin
               presc <= '0;
               ticks <= ticks + 1'b1;
            end else begin
               presc <= presc + 1'b1;
            end
         end

         // Outputs decoded from next state and registered: glitch-free, aligned with state.
         controlServo <= (state_nxt == DOWN);
         busy         <= (state_nxt != IDLE);
         done         <= (state_nxt == DONE);
      end
   end

`ifdef WASHER_DISPENSER_COUNT_EN
   logic [7:0] cnt;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                cnt <= 8'd0;
      else if (state == DONE) cnt <= cnt + 8'd1;
   end
   assign dispCount = cnt;
`else
   assign dispCount = 8'd0;
`endif

endmodule

// File: doc/washer_dispenser.md
WASHER_DISPENSER -- requirements
Module: washer_dispenser

Interface
REQ-001 SHALL have parameter DIV, default 100000, meaning clock cycles per timing tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter DOWN_TICKS, default 300, meaning ticks the servo is held down per dispense.
REQ-003 SHALL have parameter UP_TICKS, default 300, meaning ticks the servo is held up after each dispense to settle.
REQ-004 SHALL have port CLK, input, 1, the single clock; all flops on posedge.
REQ-005 SHALL have port RST, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port request, input, 1, asynchronous dispense request; each rising edge means one washer.
REQ-007 SHALL have port controlServo, output, 1, 1 = servo down, 0 = servo up; drives the downstream washer PWM stage.
REQ-008 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-009 SHALL have port done, output, 1, one-cycle pulse at the end of each dispense.
REQ-010 SHALL have port overflow, output, 1, sticky flag: a request was dropped.
REQ-011 SHALL have port dispCount, output, 8, count of completed dispenses.

Function
REQ-012 SHALL pass request through a 2-flop synchronizer plus one history flop; edge = sync2 & ~hist.
REQ-013 SHALL hold a 2-bit pending counter: +1 on edge, -1 when the FSM leaves IDLE, net 0 when both occur in the same cycle.
REQ-014 SHALL saturate pending at 3; an edge arriving while pending = 3 with no same-cycle decrement SHALL set overflow and drop that request.
REQ-015 SHALL implement the FSM states IDLE, DOWN, UP, DONE.
REQ-016 SHALL go IDLE->DOWN on the cycle after pending > 0 is seen in IDLE, and DOWN->UP after exactly DOWN_TICKS*DIV cycles in DOWN.
REQ-017 SHALL go UP->DONE after exactly UP_TICKS*DIV cycles in UP, and DONE->IDLE after 1 cycle.
REQ-018 SHALL restart the prescaler (0..DIV-1) and tick counter to 0 on every state entry, so that durations are exact and independent of request timing.
REQ-019 SHALL drive controlServo = 1 only in DOWN, and SHALL register it (no glitches).
REQ-020 SHALL drive done = 1 only in DONE and busy = 1 in DOWN, UP and DONE.
REQ-021 SHALL increment dispCount in DONE, wrapping 255->0.
REQ-022 SHALL size counter widths with $clog2 of the parameters; DOWN_TICKS, UP_TICKS and DIV are each >= 1.
REQ-023 SHALL ignore request level while busy, other than queuing edges via pending.

Reset
REQ-024 SHALL on RST immediately set the FSM to IDLE and clear controlServo, busy, done, overflow, pending, dispCount, the prescaler, the tick counter and the synchronizer flops.
REQ-025 SHALL treat reset mid-dispense as aborting it: the servo returns up at once, no done pulse is produced, and the count is unchanged from its reset value 0.
REQ-026 SHALL not detect a request held high through reset release as an edge until it falls and rises again, because hist is cleared to 0 but sync must fill first.

Configuration
REQ-027 SHALL implement dispCount and its increment logic only when WASHER_DISPENSER_COUNT_EN is defined.
REQ-028 SHALL tie dispCount to constant 0 when WASHER_DISPENSER_COUNT_EN is not defined; all other behaviour is identical.

Verification (DIV=4, DOWN_TICKS=3, UP_TICKS=2)
REQ-029 SHALL cover a single request pulse -> controlServo high for exactly 12 cycles, low for 8 cycles, done for 1 cycle, dispCount=1, busy low afterwards.
REQ-030 SHALL cover 3 edges inside one dispense -> 4 back-to-back dispenses, one idle cycle between each, and overflow stays 0.
REQ-031 SHALL cover 5 edges during the first DOWN phase -> 4 dispenses total, overflow=1, and overflow still set after completion.
REQ-032 SHALL cover RST asserted at cycle 6 of DOWN -> controlServo=0 asynchronously, pending=0, dispCount=0, and no done pulse.
REQ-033 SHALL cover 256 dispenses -> dispCount wraps to 0; with the macro undefined, dispCount stays 0 throughout.
REQ-034 SHALL cover an edge coinciding with the IDLE->DOWN departure while pending=3 -> pending stays 3 and overflow stays 0.
